// File: rtl/otter_pkg.sv
// Shared constants for the OTTER branch-predictor performance monitor:
// opcodes, PC-mux encodings, register offsets and the monitor state type.
package otter_pkg;

   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;

   localparam logic [2:0] PCS_PC4    = 3'd0;
   localparam logic [2:0] PCS_JALR   = 3'd1;
   localparam logic [2:0] PCS_BRANCH = 3'd2;
   localparam logic [2:0] PCS_JAL    = 3'd3;
   localparam logic [2:0] PCS_MTVEC  = 3'd4;
   localparam logic [2:0] PCS_MEPC   = 3'd5;

   localparam logic [4:0] REG_CTRL    = 5'h00;
   localparam logic [4:0] REG_INSTRET = 5'h04;
   localparam logic [4:0] REG_BRANCH  = 5'h08;
   localparam logic [4:0] REG_TAKEN   = 5'h0C;
   localparam logic [4:0] REG_MISPRED = 5'h10;
   localparam logic [4:0] REG_JUMP    = 5'h14;

   localparam int unsigned WINDOW_BYTES = 32;
   localparam int unsigned NUM_EVENTS   = 5;

   typedef enum logic {
      RUN  = 1'b0,
      HOLD = 1'b1
   } bpmon_state_t;

endpackage

// File: rtl/sat_counter32.sv
// 32-bit event counter that sticks at all-ones instead of wrapping.
// Clear has priority over increment; reset has priority over both.
module sat_counter32 (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        inc,
   input  logic        clr,
   output logic [31:0] count
);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         count <= 32'd0;
      end else if (clr) begin
         count <= 32'd0;
      end else if (inc && (count != 32'hFFFF_FFFF)) begin
         count <= count + 32'd1;
      end
   end

endmodule

// File: rtl/bp_perf_counter.sv
// Memory-mapped branch-predictor performance monitor: classifies each commit,
// counts events in saturating counters and exposes snapshot copies on the IOBUS.
module bp_perf_counter
   import otter_pkg::*;
#(
   parameter logic [31:0] BASE_ADDR = 32'h1100_0100
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        data_valid,
   input  logic [6:0]  opcode,
   input  logic [2:0]  pcSource,
   input  logic        pred_taken,
   input  logic [31:0] IOBUS_ADDR,
   input  logic [31:0] IOBUS_OUT,
   input  logic        IOBUS_WR,
   output logic [31:0] rd_data,
   output logic        hit
);

   bpmon_state_t state;
   logic         en;

   logic [31:0] offset;
   logic        in_window;
   logic        wr_ctrl;
   logic        do_clr;
   logic        do_snap;

   logic        count_en;
   logic        is_trap;
   logic        is_branch;
   logic        actual_taken;
   logic [NUM_EVENTS-1:0] inc;

   logic [31:0] live   [NUM_EVENTS];
   logic [31:0] shadow [NUM_EVENTS];

   logic unused_bits;

   assign offset    = IOBUS_ADDR - BASE_ADDR;
   assign in_window = offset < 32'(WINDOW_BYTES);
   assign wr_ctrl   = IOBUS_WR && (IOBUS_ADDR == BASE_ADDR);
   assign do_clr    = wr_ctrl && IOBUS_OUT[1];
   assign do_snap   = wr_ctrl && IOBUS_OUT[2];

   assign unused_bits = ^{IOBUS_OUT[31:3], offset[31:5]};

   // Trap entry/return commits are plain retirements, never control-flow events.
   assign count_en     = data_valid && (state == RUN);
   assign is_trap      = (pcSource == PCS_MTVEC) || (pcSource == PCS_MEPC);
   assign is_branch    = (opcode == OP_BRANCH) && !is_trap;
   assign actual_taken = (pcSource == PCS_BRANCH);

   assign inc[0] = count_en;
   assign inc[1] = count_en && is_branch;
   assign inc[2] = count_en && is_branch && actual_taken;
   assign inc[3] = count_en && is_branch && (pred_taken != actual_taken);
   assign inc[4] = count_en && !is_trap && ((opcode == OP_JAL) || (opcode == OP_JALR));

   sat_counter32 u_instret (.clk(CLK), .rst_n(RST), .inc(inc[0]), .clr(do_clr), .count(live[0]));
   sat_counter32 u_branch  (.clk(CLK), .rst_n(RST), .inc(inc[1]), .clr(do_clr), .count(live[1]));
   sat_counter32 u_taken   (.clk(CLK), .rst_n(RST), .inc(inc[2]), .clr(do_clr), .count(live[2]));
   sat_counter32 u_mispred (.clk(CLK), .rst_n(RST), .inc(inc[3]), .clr(do_clr), .count(live[3]));
   sat_counter32 u_jump    (.clk(CLK), .rst_n(RST), .inc(inc[4]), .clr(do_clr), .count(live[4]));

   // State follows EN on the write edge, so a commit in that cycle still counts.
   always_ff @(posedge CLK) begin
      if (!RST) begin
         state <= RUN;
         en    <= 1'b1;
      end else if (wr_ctrl) begin
         en    <= IOBUS_OUT[0];
         state <= IOBUS_OUT[0] ? RUN : HOLD;
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST || do_clr) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            shadow[i] <= 32'd0;
         end
      end else if (do_snap) begin
         for (int i = 0; i < NUM_EVENTS; i++) begin
            shadow[i] <= live[i];
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (!RST) begin
         rd_data <= 32'd0;
         hit     <= 1'b0;
      end else begin
         hit     <= in_window;
         rd_data <= 32'd0;
         if (in_window) begin
            case (offset[4:0])
               REG_CTRL:    rd_data <= {28'd0, (state == HOLD), 2'b00, en};
               REG_INSTRET: rd_data <= shadow[0];
               REG_BRANCH:  rd_data <= shadow[1];
               REG_TAKEN:   rd_data <= shadow[2];
               REG_MISPRED: rd_data <= shadow[3];
               REG_JUMP:    rd_data <= shadow[4];
               default:     rd_data <= 32'd0;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_bp_perf_counter.sv
// Self-checking bench for bp_perf_counter: directed scenarios plus a randomized
// run, all compared against an event-level reference model kept in the bench.
module tb_bp_perf_counter;

   localparam logic [31:0] BASE = 32'h1100_0100;
   localparam logic [31:0] SAT  = 32'hFFFF_FFFF;
   localparam logic [6:0]  ADDI = 7'b0010011;
   localparam logic [6:0]  BR   = 7'b1100011;
   localparam logic [6:0]  JAL  = 7'b1101111;
   localparam logic [6:0]  JALR = 7'b1100111;
   localparam logic [6:0]  LOAD = 7'b0000011;

   logic        CLK = 1'b0;
   logic        RST = 1'b0;
   logic        data_valid = 1'b0;
   logic [6:0]  opcode = ADDI;
   logic [2:0]  pcSource = 3'd0;
   logic        pred_taken = 1'b0;
   logic [31:0] IOBUS_ADDR = 32'd0;
   logic [31:0] IOBUS_OUT = 32'd0;
   logic        IOBUS_WR = 1'b0;
   logic [31:0] rd_data;
   logic        hit;

   int checks = 0;
   int errors = 0;

   logic [31:0] m_cnt [5];
   logic [31:0] m_shd [5];
   bit          m_en;
   string       names [5] = '{"INSTRET", "BRANCH", "TAKEN", "MISPRED", "JUMP"};

   bp_perf_counter #(.BASE_ADDR(BASE)) dut (
      .CLK(CLK),
      .RST(RST),
      .data_valid(data_valid),
      .opcode(opcode),
      .pcSource(pcSource),
      .pred_taken(pred_taken),
      .IOBUS_ADDR(IOBUS_ADDR),
      .IOBUS_OUT(IOBUS_OUT),
      .IOBUS_WR(IOBUS_WR),
      .rd_data(rd_data),
      .hit(hit)
   );

   always #5 CLK = ~CLK;

   // Which of the five events a commit produces; trap commits only retire.
   function automatic logic [4:0] model_events(input logic [6:0] op, input logic [2:0] pcs, input logic pred);
      logic [4:0] ev;
      bit ctl;
      bit br;
      ctl   = (pcs < 3'd4);
      br    = ctl && (op == BR);
      ev[0] = 1'b1;
      ev[1] = br;
      ev[2] = br && (pcs == 3'd2);
      ev[3] = br && (pred != (pcs == 3'd2));
      ev[4] = ctl && ((op == JAL) || (op == JALR));
      return ev;
   endfunction

   function automatic logic [31:0] model_reg(input logic [31:0] off);
      if (off == 32'h0) return {28'd0, !m_en, 2'b00, m_en};
      if (off >= 32'h4 && off <= 32'h14 && off[1:0] == 2'b00) return m_shd[off/4 - 1];
      return 32'd0;
   endfunction

   // Advance the model by one edge using the currently driven inputs, then clock the DUT.
   task automatic step();
      logic [4:0] ev;
      bit wr;
      wr = IOBUS_WR && (IOBUS_ADDR == BASE);
      if (!RST) begin
         for (int i = 0; i < 5; i++) begin
            m_cnt[i] = 32'd0;
            m_shd[i] = 32'd0;
         end
         m_en = 1'b1;
      end else begin
         ev = model_events(opcode, pcSource, pred_taken);
         if (wr && IOBUS_OUT[1]) begin
            for (int i = 0; i < 5; i++) begin
               m_cnt[i] = 32'd0;
               m_shd[i] = 32'd0;
            end
         end else begin
            if (wr && IOBUS_OUT[2]) begin
               for (int i = 0; i < 5; i++) m_shd[i] = m_cnt[i];
            end
            if (data_valid && m_en) begin
               for (int i = 0; i < 5; i++) begin
                  if (ev[i] && m_cnt[i] != SAT) m_cnt[i] = m_cnt[i] + 32'd1;
               end
            end
         end
         if (wr) m_en = IOBUS_OUT[0];
      end
      @(posedge CLK);
      #1;
   endtask

   task automatic commit(input logic [6:0] op, input logic [2:0] pcs, input logic pred);
      opcode     = op;
      pcSource   = pcs;
      pred_taken = pred;
      data_valid = 1'b1;
      step();
      data_valid = 1'b0;
   endtask

   task automatic write_ctrl(input logic [31:0] val);
      IOBUS_ADDR = BASE;
      IOBUS_OUT  = val;
      IOBUS_WR   = 1'b1;
      step();
      IOBUS_WR   = 1'b0;
   endtask

   task automatic read_reg(input logic [31:0] off, output logic [31:0] d, output logic h);
      IOBUS_ADDR = BASE + off;
      IOBUS_WR   = 1'b0;
      data_valid = 1'b0;
      step();
      d = rd_data;
      h = hit;
   endtask

   task automatic test_reset();
      logic [31:0] d;
      logic h;
      RST        = 1'b0;
      opcode     = BR;
      pcSource   = 3'd2;
      data_valid = 1'b1;
      IOBUS_ADDR = BASE;
      IOBUS_OUT  = 32'h4;
      IOBUS_WR   = 1'b1;
      step();
      step();
      RST        = 1'b1;
      data_valid = 1'b0;
      IOBUS_WR   = 1'b0;
      checks++;
      if (rd_data !== 32'd0 || hit !== 1'b0) begin
         errors++;
         $display("FAIL reset_outputs: rd_data=%h hit=%b, expected 00000000/0", rd_data, hit);
      end
      read_reg(32'h0, d, h);
      checks++;
      if (d !== 32'h1 || h !== 1'b1) begin
         errors++;
         $display("FAIL reset_ctrl: got %h hit=%b, expected 00000001/1", d, h);
      end
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL reset_%s: got %h, expected 00000000", names[i], d);
         end
      end
   endtask

   task automatic test_counting();
      logic [31:0] d;
      logic h;
      logic [31:0] exp [5] = '{32'd19, 32'd7, 32'd4, 32'd3, 32'd2};
      write_ctrl(32'h3);
      for (int i = 0; i < 10; i++) commit(ADDI, 3'd0, 1'b0);
      for (int i = 0; i < 4; i++) commit(BR, 3'd2, 1'b1);
      for (int i = 0; i < 3; i++) commit(BR, 3'd0, 1'b1);
      for (int i = 0; i < 2; i++) commit(JAL, 3'd3, 1'b0);
      write_ctrl(32'h5);
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== exp[i]) begin
            errors++;
            $display("FAIL count_%s: got %0d, expected %0d", names[i], d, exp[i]);
         end
      end
   endtask

   task automatic test_snapshot();
      logic [31:0] d;
      logic h;
      for (int i = 0; i < 5; i++) commit(ADDI, 3'd0, 1'b0);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd19) begin
         errors++;
         $display("FAIL snap_isolated: got %0d, expected 19", d);
      end
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd24) begin
         errors++;
         $display("FAIL snap_second: got %0d, expected 24", d);
      end
      opcode     = ADDI;
      pcSource   = 3'd0;
      data_valid = 1'b1;
      IOBUS_ADDR = BASE;
      IOBUS_OUT  = 32'h5;
      IOBUS_WR   = 1'b1;
      step();
      data_valid = 1'b0;
      IOBUS_WR   = 1'b0;
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd24) begin
         errors++;
         $display("FAIL snap_with_commit: got %0d, expected 24", d);
      end
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd25) begin
         errors++;
         $display("FAIL snap_after_commit: got %0d, expected 25", d);
      end
   endtask

   task automatic test_freeze();
      logic [31:0] d;
      logic h;
      write_ctrl(32'h0);
      read_reg(32'h0, d, h);
      checks++;
      if (d !== 32'h8) begin
         errors++;
         $display("FAIL freeze_ctrl: got %h, expected 00000008", d);
      end
      for (int i = 0; i < 8; i++) commit((i % 2 == 0) ? BR : JALR, 3'(i % 4), i[0]);
      write_ctrl(32'h4);
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== m_shd[i]) begin
            errors++;
            $display("FAIL freeze_%s: got %0d, expected %0d", names[i], d, m_shd[i]);
         end
      end
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd25) begin
         errors++;
         $display("FAIL freeze_instret_held: got %0d, expected 25", d);
      end
      write_ctrl(32'h1);
      commit(ADDI, 3'd0, 1'b0);
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd26) begin
         errors++;
         $display("FAIL resume_instret: got %0d, expected 26", d);
      end
      opcode     = ADDI;
      data_valid = 1'b1;
      IOBUS_ADDR = BASE;
      IOBUS_OUT  = 32'h0;
      IOBUS_WR   = 1'b1;
      step();
      IOBUS_WR   = 1'b0;
      step();
      data_valid = 1'b0;
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd27) begin
         errors++;
         $display("FAIL disable_in_commit: got %0d, expected 27", d);
      end
   endtask

   task automatic test_clear_priority();
      logic [31:0] d;
      logic h;
      opcode     = BR;
      pcSource   = 3'd2;
      pred_taken = 1'b0;
      data_valid = 1'b1;
      IOBUS_ADDR = BASE;
      IOBUS_OUT  = 32'h7;
      IOBUS_WR   = 1'b1;
      step();
      data_valid = 1'b0;
      IOBUS_WR   = 1'b0;
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL clr_shadow_%s: got %0d, expected 0", names[i], d);
         end
      end
      write_ctrl(32'h5);
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== 32'd0) begin
            errors++;
            $display("FAIL clr_live_%s: got %0d, expected 0", names[i], d);
         end
      end
   endtask

   task automatic test_saturation();
      logic [31:0] d;
      logic h;
      force dut.u_instret.count = 32'hFFFF_FFFE;
      @(negedge CLK);
      release dut.u_instret.count;
      m_cnt[0] = 32'hFFFF_FFFE;
      for (int i = 0; i < 3; i++) commit(ADDI, 3'd0, 1'b0);
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== SAT) begin
         errors++;
         $display("FAIL sat_reach: got %h, expected %h", d, SAT);
      end
      for (int i = 0; i < 2; i++) commit(ADDI, 3'd0, 1'b0);
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== SAT) begin
         errors++;
         $display("FAIL sat_hold: got %h, expected %h", d, SAT);
      end
      write_ctrl(32'h3);
      write_ctrl(32'h5);
      read_reg(32'h4, d, h);
      checks++;
      if (d !== 32'd0) begin
         errors++;
         $display("FAIL sat_clear: got %h, expected 00000000", d);
      end
      read_reg(32'h18, d, h);
      checks++;
      if (d !== 32'd0 || h !== 1'b1) begin
         errors++;
         $display("FAIL unmapped_read: got %h hit=%b, expected 00000000/1", d, h);
      end
      read_reg(32'h20, d, h);
      checks++;
      if (d !== 32'd0 || h !== 1'b0) begin
         errors++;
         $display("FAIL outside_window: got %h hit=%b, expected 00000000/0", d, h);
      end
   endtask

   task automatic test_random();
      logic [6:0] ops [5] = '{ADDI, BR, JAL, JALR, LOAD};
      logic [31:0] off;
      logic [31:0] exp_d;
      logic exp_h;
      logic [31:0] d;
      logic h;
      for (int n = 0; n < 400; n++) begin
         off        = 32'($urandom_range(0, 40));
         opcode     = ops[$urandom_range(0, 4)];
         pcSource   = 3'($urandom_range(0, 5));
         pred_taken = 1'($urandom_range(0, 1));
         data_valid = ($urandom_range(0, 3) != 0);
         IOBUS_WR   = 1'b0;
         if ($urandom_range(0, 9) == 0) begin
            off       = 32'd0;
            IOBUS_WR  = 1'b1;
            IOBUS_OUT = {29'($urandom), ($urandom_range(0, 1) == 1),
                         ($urandom_range(0, 7) == 0), ($urandom_range(0, 3) != 0)};
         end else if ($urandom_range(0, 4) == 0) begin
            IOBUS_WR  = 1'b1;
            IOBUS_OUT = $urandom;
         end
         IOBUS_ADDR = BASE + off;
         exp_d = model_reg(off);
         exp_h = (off < 32'd32);
         step();
         checks++;
         if (rd_data !== exp_d || hit !== exp_h) begin
            errors++;
            $display("FAIL random_read[%0d] off=%h: got %h hit=%b, expected %h/%b", n, off, rd_data, hit, exp_d, exp_h);
         end
      end
      data_valid = 1'b0;
      IOBUS_WR   = 1'b0;
      write_ctrl(32'h5);
      for (int i = 0; i < 5; i++) begin
         read_reg(32'(4 * (i + 1)), d, h);
         checks++;
         if (d !== m_shd[i]) begin
            errors++;
            $display("FAIL random_final_%s: got %0d, expected %0d", names[i], d, m_shd[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_counting();
      test_snapshot();
      test_freeze();
      test_clear_priority();
      test_saturation();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/bp_perf_counter.md
# bp_perf_counter

Memory-mapped performance monitor for the OTTER branch predictor. It watches every instruction commit (`pcWrite` pulse), classifies control-flow instructions from `opcode`/`pcSource`, and compares the actual branch outcome against the predictor's taken/not-taken guess. Five saturating 32-bit event counters are captured into shadow registers on command and read back over the IOBUS, so software can measure prediction accuracy without halting the core.

## Interface
- `BASE_ADDR`, default `32'h1100_0100`: IOBUS base address of the register window (0x20 bytes).
- `CLK`  in  1  system clock; all state updates on the rising edge.
- `RST`  in  1  synchronous, active-low reset.
- `data_valid`  in  1  commit strobe (core `pcWrite`); one instruction retires in each cycle it is high.
- `opcode`  in  7  `ir[6:0]` of the committing instruction.
- `pcSource`  in  3  PC mux select of the committing instruction (0 pc+4, 1 jalr, 2 branch, 3 jal, 4 mtvec, 5 mepc).
- `pred_taken`  in  1  predictor guess for the committing instruction; sampled only when a branch commits.
- `IOBUS_ADDR`  in  32  bus address.
- `IOBUS_OUT`  in  32  bus write data.
- `IOBUS_WR`  in  1  bus write strobe.
- `rd_data`  out  32  registered read data for `IOBUS_ADDR`.
- `hit`  out  1  registered; high when the previous-cycle `IOBUS_ADDR` fell inside the window.

## Operation
- **Event classification** (only when `data_valid`=1 and counting is enabled):
  - INSTRET increments on every commit.
  - BRANCH increments when `opcode`=7'b1100011.
  - TAKEN increments on a branch with `pcSource`=2.
  - MISPRED increments on a branch with `pred_taken` != (`pcSource`==2).
  - JUMP increments when `opcode` is 7'b1101111 (jal) or 7'b1100111 (jalr).
  - Commits with `pcSource` 4 or 5 (trap entry or return) count only toward INSTRET.
- **Saturation:** every counter saturates at 32'hFFFF_FFFF and never wraps.
- **Register map** (offset from `BASE_ADDR`):
  - 0x00 CTRL, R/W: bit0 EN (reset value 1); bit1 CLR; bit2 SNAP; bit3 FROZEN (read-only).
  - 0x04 INSTRET, 0x08 BRANCH, 0x0C TAKEN, 0x10 MISPRED, 0x14 JUMP: read-only. Reads return the shadow copies, not the live counters.
  - Unmapped offsets inside the window read 0. Writes to them are ignored.
- **CTRL write** (`IOBUS_WR`=1, address = BASE+0x00):
  - EN is stored.
  - CLR=1 zeroes the live counters and the shadows.
  - SNAP=1 copies all live counters into the shadows in the same edge.
  - CLR and SNAP are self-clearing and always read 0.
- **State machine**, states RUN / HOLD:
  - RUN while EN=1. HOLD while EN=0.
  - In HOLD the counters keep their values and the shadows still respond to SNAP.
  - FROZEN = (state==HOLD).
  - A write of EN moves the state on the next edge.

## Timing
- **Reset** (`RST`=0 at an edge): all counters and shadows = 0, state = RUN, EN = 1, `rd_data` = 0, `hit` = 0. Reset overrides every simultaneous event, including in-flight bus writes.
- **Counters:** update on the same edge that samples `data_valid`. A live counter shows the new value one cycle after the commit.
- **Read latency:** 1 cycle. `rd_data` and `hit` reflect the `IOBUS_ADDR` sampled at the previous edge.
- **Simultaneous events:**
  - CLR together with a commit: the clear wins and the counters are 0 afterwards.
  - SNAP together with a commit: the shadows capture the pre-increment values; the live counters still increment.
  - CLR and SNAP together: CLR wins and the shadows are 0.
  - EN=0 written in a commit cycle: that commit is still counted, because the state changes after the edge.
- **Saturation with CLR:** a saturated counter stays at all-ones until CLR or reset.

## Structure
- Shared package `otter_pkg`:
  - opcode constants `OP_BRANCH`, `OP_JAL`, `OP_JALR`;
  - `pcSource` encodings `PCS_PC4` … `PCS_MEPC`;
  - register offset constants;
  - state enum `bpmon_state_t` {RUN, HOLD}.
- One sub-module `sat_counter32`: 32-bit saturating counter with inputs `inc` and `clr`. Instantiated five times.
- Shadow registers, decode, and read mux stay in the top module.

## Test plan
- **Reset:** hold `RST`=0 for 2 cycles with commits pending. Then: all reads return 0, CTRL reads 0x1, `hit`=0.
- **Counting:** 10 commits of `addi`, 4 branches with `pcSource`=2 and `pred_taken`=1, 3 branches with `pcSource`=0 and `pred_taken`=1, 2 jal, then SNAP. Expected reads: INSTRET=19, BRANCH=7, TAKEN=4, MISPRED=3, JUMP=2.
- **Snapshot isolation:** SNAP, then 5 more commits. INSTRET still reads the old value; a second SNAP adds 5. A SNAP in the same cycle as a commit excludes that commit from the shadow.
- **Freeze:**
  - Write CTRL=0, then 8 commits, then SNAP: counts unchanged and CTRL reads 0x8.
  - Write CTRL=1: counting resumes on the next commit.
- **Clear priority:** CLR|SNAP written in a branch-commit cycle. Afterwards all shadows and live counters are 0 and the branch is not counted.
- **Saturation:** force INSTRET to 32'hFFFF_FFFE (hierarchical deposit), then 3 commits. Reads 32'hFFFF_FFFF and stays there; CLR returns it to 0. A read at BASE+0x18 returns 0 with `hit`=1, and a read at BASE+0x20 returns `hit`=0.
